// File: rtl/branch_predictor_if.sv
// Fetch-side prediction and execute-side resolution signals of the branch predictor.
// The predictor connects through the slave modport and the core pipeline through the master modport.
interface branch_predictor_if #(
    parameter int XLEN     = 32,
    parameter int PHT_BITS = 6
);
    logic [XLEN-1:0]     pred_pc;
    logic                pred_taken;
    logic [XLEN-1:0]     pred_target;
    logic [PHT_BITS-1:0] pred_idx;

    logic                upd_valid;
    logic [XLEN-1:0]     upd_pc;
    logic [PHT_BITS-1:0] upd_idx;
    logic                upd_is_branch;
    logic                upd_is_jal;
    logic [2:0]          upd_func3;
    logic                upd_eq;
    logic                upd_lt;
    logic [XLEN-1:0]     upd_target;
    logic                upd_pred_taken;
    logic [XLEN-1:0]     upd_pred_target;
    logic                upd_taken;
    logic                mispredict;
    logic [XLEN-1:0]     redirect_pc;

    modport master (
        output pred_pc, upd_valid, upd_pc, upd_idx, upd_is_branch, upd_is_jal,
               upd_func3, upd_eq, upd_lt, upd_target, upd_pred_taken, upd_pred_target,
        input  pred_taken, pred_target, pred_idx, upd_taken, mispredict, redirect_pc
    );

    modport slave (
        input  pred_pc, upd_valid, upd_pc, upd_idx, upd_is_branch, upd_is_jal,
               upd_func3, upd_eq, upd_lt, upd_target, upd_pred_taken, upd_pred_target,
        output pred_taken, pred_target, pred_idx, upd_taken, mispredict, redirect_pc
    );
endinterface

// File: rtl/branch_predictor.sv
// Gshare PHT + direct-mapped BTB predictor with execute-stage resolution and training.
// Prediction and resolution are combinational (0 cycles); tables update at the clock edge; no backpressure.
module branch_predictor #(
    parameter int XLEN     = 32,
    parameter int PHT_BITS = 6,
    parameter int GHR_BITS = 4,
    parameter int BTB_BITS = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    branch_predictor_if.slave   bp
);
    localparam int PHT_N = 1 << PHT_BITS;
    localparam int BTB_N = 1 << BTB_BITS;
    localparam int TAG_W = XLEN - BTB_BITS - 2;
    localparam int GW    = (GHR_BITS > 0) ? GHR_BITS : 1;

    logic [1:0]       pht        [PHT_N];
    logic             btb_valid  [BTB_N];
    logic [TAG_W-1:0] btb_tag    [BTB_N];
    logic [XLEN-1:0]  btb_target [BTB_N];
    logic             btb_jal    [BTB_N];
    logic [GW-1:0]    ghr;

    logic [PHT_BITS-1:0] hist;
    logic [PHT_BITS-1:0] pidx;
    logic [BTB_BITS-1:0] pbidx;
    logic [TAG_W-1:0]    ptag;
    logic                hit;

    generate
        if (GHR_BITS > 0) begin : g_hist
            assign hist = PHT_BITS'(ghr);
        end else begin : g_bimodal
            assign hist = '0;
        end
    endgenerate

    assign pidx  = bp.pred_pc[PHT_BITS+1:2] ^ hist;
    assign pbidx = bp.pred_pc[BTB_BITS+1:2];
    assign ptag  = bp.pred_pc[XLEN-1:BTB_BITS+2];
    assign hit   = btb_valid[pbidx] && (btb_tag[pbidx] == ptag);

    // A JAL entry in the BTB is unconditional; branches still consult the counter.
    assign bp.pred_taken  = hit & (btb_jal[pbidx] | pht[pidx][1]);
    assign bp.pred_target = hit ? btb_target[pbidx] : '0;
    assign bp.pred_idx    = pidx;

    logic                legal;
    logic                br_taken;
    logic                is_jal;
    logic                is_br;
    logic                taken;
    logic [BTB_BITS-1:0] ubidx;
    logic [TAG_W-1:0]    utag;

    always_comb begin
        legal    = 1'b0;
        br_taken = 1'b0;
        case (bp.upd_func3)
            3'b000:         begin legal = 1'b1; br_taken = bp.upd_eq;  end
            3'b001:         begin legal = 1'b1; br_taken = ~bp.upd_eq; end
            3'b100, 3'b110: begin legal = 1'b1; br_taken = bp.upd_lt;  end
            3'b101, 3'b111: begin legal = 1'b1; br_taken = ~bp.upd_lt; end
            default:        begin legal = 1'b0; br_taken = 1'b0;       end
        endcase
    end

    // JAL takes precedence when both instruction-class flags are raised.
    assign is_jal = bp.upd_valid & bp.upd_is_jal;
    assign is_br  = bp.upd_valid & bp.upd_is_branch & ~bp.upd_is_jal;
    assign taken  = is_jal | (is_br & legal & br_taken);
    assign ubidx  = bp.upd_pc[BTB_BITS+1:2];
    assign utag   = bp.upd_pc[XLEN-1:BTB_BITS+2];

    assign bp.upd_taken   = taken;
    assign bp.mispredict  = bp.upd_valid & (bp.upd_is_branch | bp.upd_is_jal) &
                            ((taken != bp.upd_pred_taken) |
                             (taken & (bp.upd_target != bp.upd_pred_target)));
    assign bp.redirect_pc = taken ? bp.upd_target : bp.upd_pc + XLEN'(4);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < PHT_N; i++) begin
                pht[i] <= 2'b01;
            end
            for (int i = 0; i < BTB_N; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_jal[i]    <= 1'b0;
            end
            ghr <= '0;
        end else begin
            if (is_br && legal) begin
                if (br_taken && pht[bp.upd_idx] != 2'b11) begin
                    pht[bp.upd_idx] <= pht[bp.upd_idx] + 2'd1;
                end else if (!br_taken && pht[bp.upd_idx] != 2'b00) begin
                    pht[bp.upd_idx] <= pht[bp.upd_idx] - 2'd1;
                end
                if (GHR_BITS > 0) begin
                    ghr <= (ghr << 1) | GW'(br_taken);
                end
            end
            if (taken) begin
                btb_valid[ubidx]  <= 1'b1;
                btb_tag[ubidx]    <= utag;
                btb_target[ubidx] <= bp.upd_target;
                btb_jal[ubidx]    <= is_jal;
            end
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^bp.pred_pc[1:0];
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a table-level model checked every cycle plus literal spot checks.
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_predictor_if #(.XLEN(32), .PHT_BITS(6)) bp ();

    branch_predictor #(.XLEN(32), .PHT_BITS(6), .GHR_BITS(4), .BTB_BITS(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bp    (bp)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: plain integer tables indexed by the entry number.
    int          m_pht [64];
    bit          m_bv  [16];
    int unsigned m_btag[16];
    int unsigned m_btgt[16];
    bit          m_bjal[16];
    int          m_ghr;
    bit          model_ok = 1'b0;

    function automatic bit legal_f3(input logic [2:0] f);
        return (f != 3'd2) && (f != 3'd3);
    endfunction

    function automatic bit outcome(input logic [2:0] f, input logic eq, input logic lt);
        case (f)
            3'd0:       return eq;
            3'd1:       return !eq;
            3'd4, 3'd6: return lt;
            default:    return !lt;
        endcase
    endfunction

    always @(posedge clk) begin : model_update
        int          ub;
        bit          t;
        if (rst) begin
            for (int i = 0; i < 64; i++) m_pht[i] <= 1;
            for (int i = 0; i < 16; i++) m_bv[i] <= 1'b0;
            m_ghr    <= 0;
            model_ok <= 1'b1;
        end else if (model_ok && bp.upd_valid) begin
            ub = int'((bp.upd_pc >> 2) % 16);
            if (bp.upd_is_jal) begin
                m_bv[ub] <= 1'b1; m_btag[ub] <= bp.upd_pc >> 6;
                m_btgt[ub] <= bp.upd_target; m_bjal[ub] <= 1'b1;
            end else if (bp.upd_is_branch && legal_f3(bp.upd_func3)) begin
                t = outcome(bp.upd_func3, bp.upd_eq, bp.upd_lt);
                if (t) m_pht[bp.upd_idx] <= (m_pht[bp.upd_idx] >= 3) ? 3 : m_pht[bp.upd_idx] + 1;
                else   m_pht[bp.upd_idx] <= (m_pht[bp.upd_idx] <= 0) ? 0 : m_pht[bp.upd_idx] - 1;
                m_ghr <= ((m_ghr * 2) + int'(t)) % 16;
                if (t) begin
                    m_bv[ub] <= 1'b1; m_btag[ub] <= bp.upd_pc >> 6;
                    m_btgt[ub] <= bp.upd_target; m_bjal[ub] <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin : model_compare
        int          pi, bi;
        bit          h, e_pt, e_t, e_mp;
        logic [31:0] e_rd;
        if (model_ok) begin
            pi = int'(((bp.pred_pc >> 2) ^ 32'(m_ghr)) % 64);
            bi = int'((bp.pred_pc >> 2) % 16);
            h  = m_bv[bi] && (m_btag[bi] == (bp.pred_pc >> 6));
            e_pt = h && (m_bjal[bi] || m_pht[pi] >= 2);
            chk("pred_taken", 32'(bp.pred_taken), 32'(e_pt));
            chk("pred_target", bp.pred_target, h ? m_btgt[bi] : 32'd0);
            chk("pred_idx", 32'(bp.pred_idx), 32'(pi));
            e_t = 1'b0; e_mp = 1'b0;
            if (bp.upd_valid && (bp.upd_is_branch || bp.upd_is_jal)) begin
                if (bp.upd_is_jal) e_t = 1'b1;
                else if (legal_f3(bp.upd_func3)) e_t = outcome(bp.upd_func3, bp.upd_eq, bp.upd_lt);
                e_mp = (e_t != bp.upd_pred_taken) || (e_t && bp.upd_target != bp.upd_pred_target);
            end
            chk("upd_taken", 32'(bp.upd_taken), 32'(e_t));
            chk("mispredict", 32'(bp.mispredict), 32'(e_mp));
            if (bp.upd_valid) begin
                e_rd = e_t ? bp.upd_target : bp.upd_pc + 32'd4;
                chk("redirect_pc", bp.redirect_pc, e_rd);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [5:0] idx, input logic br, input logic jal,
                       input logic [2:0] f3, input logic eq, input logic lt, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptgt);
        bp.upd_valid = 1'b1; bp.upd_pc = pc; bp.upd_idx = idx;
        bp.upd_is_branch = br; bp.upd_is_jal = jal; bp.upd_func3 = f3;
        bp.upd_eq = eq; bp.upd_lt = lt; bp.upd_target = tgt;
        bp.upd_pred_taken = pt; bp.upd_pred_target = ptgt;
    endtask

    initial begin
        bp.pred_pc = 32'h100;
        upd(32'h0, 6'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        bp.upd_valid = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_pred_taken", 32'(bp.pred_taken), 32'd0);
        chk("rst_pred_idx", 32'(bp.pred_idx), 32'h00);
        chk("rst_pht0", 32'(dut.pht[0]), 32'd1);
        chk("rst_pht63", 32'(dut.pht[63]), 32'd1);

        // Taken BEQ at 0x100 mispredicted as not-taken
        tick();
        upd(32'h100, 6'd0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 32'h80, 1'b0, 32'h0);
        @(negedge clk);
        chk("beq_taken", 32'(bp.upd_taken), 32'd1);
        chk("beq_mispredict", 32'(bp.mispredict), 32'd1);
        chk("beq_redirect", bp.redirect_pc, 32'h80);
        tick();
        bp.upd_valid = 1'b0;
        @(negedge clk);
        chk("beq_pht0", 32'(dut.pht[0]), 32'd2);
        chk("beq_ghr", 32'(dut.ghr), 32'h1);
        chk("beq_btb_target", bp.pred_target, 32'h80);
        chk("beq_pred_idx", 32'(bp.pred_idx), 32'h01);

        // Saturate PHT[5] with four taken BEQs at 0x28
        for (int k = 0; k < 4; k++) begin
            tick();
            upd(32'h28, 6'd5, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 32'h300, 1'b0, 32'h0);
        end
        tick();
        bp.upd_valid = 1'b0;
        bp.pred_pc = 32'h28;
        @(negedge clk);
        chk("sat_pht5", 32'(dut.pht[5]), 32'd3);
        chk("sat_ghr", 32'(dut.ghr), 32'hF);
        chk("sat_pred_taken", 32'(bp.pred_taken), 32'd1);
        chk("sat_pred_target", bp.pred_target, 32'h300);

        tick();
        upd(32'h28, 6'd5, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'h300, 1'b1, 32'h300);
        @(negedge clk);
        chk("nt1_mispredict", 32'(bp.mispredict), 32'd1);
        chk("nt1_redirect", bp.redirect_pc, 32'h2C);
        tick();
        @(negedge clk);
        chk("nt1_pht5", 32'(dut.pht[5]), 32'd2);
        tick();
        bp.upd_valid = 1'b0;
        @(negedge clk);
        chk("nt2_pht5", 32'(dut.pht[5]), 32'd1);

        // BGEU with lt=1, BLTU with lt=1, reserved func3
        tick();
        bp.pred_pc = 32'h100;
        upd(32'h500, 6'd7, 1'b1, 1'b0, 3'd7, 1'b0, 1'b1, 32'h700, 1'b0, 32'h0);
        @(negedge clk);
        chk("bgeu_taken", 32'(bp.upd_taken), 32'd0);
        chk("bgeu_redirect", bp.redirect_pc, 32'h504);
        tick();
        upd(32'h504, 6'd7, 1'b1, 1'b0, 3'd6, 1'b0, 1'b1, 32'h600, 1'b1, 32'h600);
        @(negedge clk);
        chk("bgeu_btb_kept", bp.pred_target, 32'h80);
        chk("bltu_taken", 32'(bp.upd_taken), 32'd1);
        chk("bltu_mispredict", 32'(bp.mispredict), 32'd0);
        tick();
        upd(32'h508, 6'd9, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 32'h900, 1'b0, 32'h0);
        @(negedge clk);
        chk("f3_010_taken", 32'(bp.upd_taken), 32'd0);
        tick();
        bp.upd_valid = 1'b0;
        @(negedge clk);
        chk("f3_010_pht9", 32'(dut.pht[9]), 32'd1);
        chk("f3_010_ghr", 32'(dut.ghr), 32'h1);

        // JAL 0x200 -> 0x400, then prediction and replay
        tick();
        upd(32'h200, 6'd3, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 32'h400, 1'b0, 32'h0);
        @(negedge clk);
        chk("jal_mispredict", 32'(bp.mispredict), 32'd1);
        chk("jal_redirect", bp.redirect_pc, 32'h400);
        tick();
        bp.upd_valid = 1'b0;
        bp.pred_pc = 32'h200;
        @(negedge clk);
        chk("jal_pred_taken", 32'(bp.pred_taken), 32'd1);
        chk("jal_pred_target", bp.pred_target, 32'h400);
        chk("jal_ghr", 32'(dut.ghr), 32'h1);
        chk("jal_pht3", 32'(dut.pht[3]), 32'd1);
        tick();
        upd(32'h200, 6'd1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 32'h400, 1'b1, 32'h400);
        @(negedge clk);
        chk("jal_replay_mp", 32'(bp.mispredict), 32'd0);
        tick();
        upd(32'h200, 6'd1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 32'h400, 1'b1, 32'h404);
        @(negedge clk);
        chk("jal_badtgt_mp", 32'(bp.mispredict), 32'd1);

        // Neither flag set, then PC wrap-around
        tick();
        upd(32'h300, 6'd2, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 32'h800, 1'b1, 32'h800);
        @(negedge clk);
        chk("noflag_mp", 32'(bp.mispredict), 32'd0);
        tick();
        upd(32'hFFFF_FFFC, 6'd2, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 32'h1000, 1'b0, 32'h0);
        @(negedge clk);
        chk("wrap_redirect", bp.redirect_pc, 32'h0000_0000);

        // Reset alongside a valid taken update
        tick();
        rst = 1'b1;
        upd(32'h300, 6'd2, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 32'h800, 1'b0, 32'h0);
        tick();
        rst = 1'b0;
        bp.upd_valid = 1'b0;
        @(negedge clk);
        chk("rst_upd_pht2", 32'(dut.pht[2]), 32'd1);
        chk("rst_upd_ghr", 32'(dut.ghr), 32'h0);
        chk("rst_upd_pred", 32'(bp.pred_taken), 32'd0);
        bp.pred_pc = 32'h300;
        #1;
        chk("rst_upd_btb", bp.pred_target, 32'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
